// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// default frame geometry.
package uart_pkg;

  localparam int UART_OVERSAMPLE_DEF = 16;
  localparam int UART_DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line. Resets to 1 so a
// freshly reset receiver sees an idle line rather than a false start bit.
module uart_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  // next values: shift the raw line through two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // stage registers with idle-high reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with a valid/ready byte output and one-clk
// frame and overrun error pulses.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | line idle, waiting for a low sample on a baud tick
// ST_START     | start bit seen, re-check it at mid-bit to reject glitches
// ST_DATA      | sampling payload bits LSB first, one per bit period
// ST_STOP      | waiting for mid-stop-bit sample; high = good frame
// ST_WAIT_IDLE | bad stop bit, wait for the line to return high (break)
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int DATA_BITS  = UART_DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 baud_tick16,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rxs;

  uart_rx_state_e       state_d, state_q;
  logic [TW-1:0]        tick_cnt_d, tick_cnt_q;
  logic [BW-1:0]        bit_cnt_d, bit_cnt_q;
  logic [DATA_BITS-1:0] shift_d, shift_q;
  logic [DATA_BITS-1:0] rx_data_d, rx_data_q;
  logic                 rx_valid_d, rx_valid_q;
  logic                 frame_err_d, frame_err_q;
  logic                 overrun_err_d, overrun_err_q;
  logic                 stop_ok, stop_bad;

  uart_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rxs)
  );

  // frame sequencing: everything here only moves on a baud tick
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    if (baud_tick16) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
          end
        end
        ST_START: begin
          if (tick_cnt_q == TICK_HALF) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rxs ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d         = '0;
            shift_d[bit_cnt_q] = rxs;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              state_d   = ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            if (rxs) begin
              stop_ok = 1'b1;
              state_d = ST_IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = ST_WAIT_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (rxs) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // output buffer: single entry, a completing frame may refill it in the
  // same cycle it is being accepted, otherwise a full buffer drops the byte
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q && !rx_ready;
    frame_err_d   = stop_bad;
    overrun_err_d = 1'b0;
    if (stop_ok) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_busy     = (state_q != ST_IDLE);
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule
